// File: rtl/mole_round_scheduler_if.sv
// rtl/mole_round_scheduler_if.sv - control/status bundle between game controller and mole round scheduler
interface mole_round_scheduler_if #(
    parameter int UP_W = 10
);
    logic            start;
    logic            time_up;
    logic            full_clear_hit;
    logic            pause;
    logic            game_in_progress;
    logic            moles_visible;
    logic            mole_clk;
    logic [UP_W-1:0] up_ms_current;
    logic [3:0]      level;

    modport master (
        output start,
        output time_up,
        output full_clear_hit,
        output pause,
        input  game_in_progress,
        input  moles_visible,
        input  mole_clk,
        input  up_ms_current,
        input  level
    );

    modport slave (
        input  start,
        input  time_up,
        input  full_clear_hit,
        input  pause,
        output game_in_progress,
        output moles_visible,
        output mole_clk,
        output up_ms_current,
        output level
    );
endinterface

// File: rtl/mole_round_scheduler.sv
// rtl/mole_round_scheduler.sv - mole up/down round sequencer with level-based up-window ramp
// Optional freeze on pause when MOLE_PAUSE_EN is defined.
module mole_round_scheduler #(
    parameter int CLKS_PER_MS      = 50000,
    parameter int UP_MS_START      = 1000,
    parameter int UP_MS_MIN        = 400,
    parameter int STEP_MS          = 100,
    parameter int DOWN_MS          = 500,
    parameter int ROUNDS_PER_LEVEL = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    mole_round_scheduler_if.slave bus
);
    localparam int UP_W   = $clog2(UP_MS_START + 1);
    localparam int PS_W   = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam int MS_MAX = (UP_MS_START > DOWN_MS) ? UP_MS_START : DOWN_MS;
    localparam int MS_W   = $clog2(MS_MAX + 1);
    localparam int RND_W  = (ROUNDS_PER_LEVEL > 1) ? $clog2(ROUNDS_PER_LEVEL) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        OVER = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic [MS_W-1:0]  ms_q, ms_d;
    logic [RND_W-1:0] round_q, round_d;
    logic [3:0]       level_q, level_d;
    logic [UP_W-1:0]  up_ms_q, up_ms_d;
    logic             gip_q, gip_d;
    logic             visible_q, visible_d;
    logic             mole_clk_q, mole_clk_d;

    logic tick;
    logic in_round;
    logic frozen;
    logic up_expire;
    logic down_expire;

    always_comb begin
        tick        = (presc_q == PS_W'(CLKS_PER_MS - 1));
        in_round    = (state_q == UP) || (state_q == DOWN);
        up_expire   = tick && (int'(ms_q) == int'(up_ms_q) - 1);
        down_expire = tick && (int'(ms_q) == DOWN_MS - 1);
`ifdef MOLE_PAUSE_EN
        frozen      = bus.pause && in_round;
`else
        frozen      = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        ms_d    = ms_q;
        round_d = round_q;
        level_d = level_q;
        up_ms_d = up_ms_q;

        // time_up outranks full_clear_hit, which outranks pause and timer expiry
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = UP;
                end
            end
            UP: begin
                if (bus.time_up) begin
                    state_d = OVER;
                end else if (bus.full_clear_hit) begin
                    state_d = DOWN;
                end else if (!frozen && up_expire) begin
                    state_d = DOWN;
                end
            end
            DOWN: begin
                if (bus.time_up) begin
                    state_d = OVER;
                end else if (!frozen && down_expire) begin
                    state_d = UP;
                    if (round_q == RND_W'(ROUNDS_PER_LEVEL - 1)) begin
                        round_d = '0;
                        if (level_q != 4'hF) begin
                            level_d = level_q + 4'd1;
                        end
                        // Clamp before subtracting so the window never wraps below the floor
                        if (int'(up_ms_q) >= UP_MS_MIN + STEP_MS) begin
                            up_ms_d = up_ms_q - UP_W'(STEP_MS);
                        end else begin
                            up_ms_d = UP_W'(UP_MS_MIN);
                        end
                    end else begin
                        round_d = round_q + RND_W'(1);
                    end
                end
            end
            default: begin
                state_d = OVER;
            end
        endcase

        if (state_d != state_q) begin
            presc_d = '0;
            ms_d    = '0;
        end else if (in_round && !frozen) begin
            if (tick) begin
                presc_d = '0;
                ms_d    = ms_q + MS_W'(1);
            end else begin
                presc_d = presc_q + PS_W'(1);
            end
        end

        gip_d      = ((state_d == UP) || (state_d == DOWN)) && !(frozen && (state_d == state_q));
        visible_d  = (state_d == UP);
        mole_clk_d = (state_d == UP) && (state_q != UP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            ms_q       <= '0;
            round_q    <= '0;
            level_q    <= 4'd0;
            up_ms_q    <= UP_W'(UP_MS_START);
            gip_q      <= 1'b0;
            visible_q  <= 1'b0;
            mole_clk_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            ms_q       <= ms_d;
            round_q    <= round_d;
            level_q    <= level_d;
            up_ms_q    <= up_ms_d;
            gip_q      <= gip_d;
            visible_q  <= visible_d;
            mole_clk_q <= mole_clk_d;
        end
    end

    assign bus.game_in_progress = gip_q;
    assign bus.moles_visible    = visible_q;
    assign bus.mole_clk         = mole_clk_q;
    assign bus.up_ms_current    = up_ms_q;
    assign bus.level            = level_q;
endmodule
